control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control sequencer that drives the ALU block's control inputs. It holds the instruction register (IR), the microstep counter and the latched ALU flags. It builds the microcode ROM address from them, decodes the returned microword into the ALU control fields, and resolves end-of-instruction and conditional flow. It sits directly upstream of alu_block, shares main_bus with it, and consumes its 4-bit fout flags.

## Interface
Parameters:
- STEP_W, 3: microstep counter width (8 steps per opcode).
- UWORD_W, 32: microword width; bits 31:25 are reserved and must be zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- main_bus  in  8  shared data bus; IR loads from it.
- fout  in  4  ALU flags {N,Z,C,V} (bit3..bit0).
- uaddr  out  11  microcode ROM address = {ir[7:0], step[2:0]}.
- uword  in  32  microword, combinational response to uaddr.
- outctl  out  4  bus driver select; 15 = none.
- loadctl  out  4  register load select; 15 = none.
- alt, calcfn  out  1 each  ALU mode controls.
- arg_l  out  2  ALU left operand select.
- arg_r  out  3  ALU right operand select.
- cin  out  1  ALU carry-in.
- flags  out  4  latched flags register.
- halted  out  1  high in HALT state.

## Operation
- Microword fields:
  - [3:0] outctl, [7:4] loadctl, [8] alt, [9] calcfn, [11:10] arg_l, [14:12] arg_r.
  - [16:15] cin_sel: 0 gives 0, 1 gives 1, 2 gives flags[1] (C), 3 gives ~flags[1].
  - [17] ir_load, [18] flags_load.
  - [21:19] flow: 0 NEXT, 1 END, 2 CEND, 3 HALT, 4-7 treated as NEXT.
  - [23:22] cond flag index (0=V, 1=C, 2=Z, 3=N), [24] cond invert.
- States: RUN, HALT.
- RUN flow:
  - NEXT: step+1; step 7 wraps to 0, which acts as an implicit END.
  - END: step set to 0.
  - CEND: if flags[cond] ^ invert, step set to 0; otherwise step+1.
  - HALT: go to HALT state, step unchanged.
- ir_load: IR is loaded from main_bus at the edge. The new IR takes effect for the next uaddr, together with the updated step.
- flags_load: flags are loaded from fout at the edge. A CEND in the same microword evaluates the old flags.
- Fetch microsteps exist in the ROM image for every opcode, so step 0 works with any IR value.
- HALT state: outctl=15, loadctl=15, all other control outputs 0. step, IR and flags are frozen; uword is ignored. Only reset leaves HALT.
- Reset values: IR=0, step=0, flags=0, state RUN, halted=0. While rst is low, outctl=15, loadctl=15 and all other control outputs are 0, regardless of uword.

## Timing
- Control outputs are purely combinational from uword (in RUN, rst high). The path is registered {IR, step} → uaddr → ROM → controls, within one clk period.
- One microstep per clk cycle. Each instruction takes 1-8 cycles.
- IR, step and flags update simultaneously on the rising clk edge. The alu_block load it commands captures on that same edge.
- Reset asserted mid-instruction:
  - Immediately forces the idle outputs.
  - Clears IR, step and flags.
  - On release, execution starts at uaddr 0.

## Configuration
- SEQ_SINGLE_STEP_EN defined: adds input step_en (1 bit). While step_en=0:
  - step, IR, flags and state hold.
  - loadctl is forced to 15.
  - Other fields still follow uword.
  While step_en=1, behaviour is identical to the macro being undefined.
- Undefined: no step_en port; the block advances every cycle.

## Structure
- Shared header seq_defs.vh holds:
  - microword field bit positions;
  - flow encodings NEXT/END/CEND/HALT;
  - cin_sel encodings;
  - flag indices V/C/Z/N;
  - idle constants OUT_NONE=15 and LOAD_NONE=15.
- Sub-module flags_reg: 4-bit register with load enable and asynchronous active-low clear. Shared later with the branch unit.

## Test plan
- Reset: rst=0 with uword=0xFFFFFF → outctl=15, loadctl=15, cin=0, uaddr=0. Release rst → halted=0, uaddr=0x000.
- NEXT wrap: eight NEXT microwords → uaddr steps 0..7. The 9th cycle returns to uaddr {ir,0}.
- IR load: main_bus=0x2A with ir_load at step 0 → next uaddr=0x151 (0x2A<<3|1). END at step 3 → uaddr=0x150.
- Flags and CEND:
  - flags_load with fout=4'b0110 → flags=0110.
  - CEND on Z (index 2, invert 0) ends the instruction (step 0).
  - CEND on Z with invert=1 advances to step+1.
  - CEND in the same word as flags_load uses the old flags.
- cin_sel: cin_sel=2 with C=1 → cin=1; cin_sel=3 → cin=0. Field passthrough check: outctl=2, loadctl=0, arg_r=1.
- HALT and single-step:
  - HALT microword → halted=1, outputs idle, uaddr frozen for 10 cycles; rst clears it.
  - With SEQ_SINGLE_STEP_EN, step_en=0 for 3 cycles → uaddr unchanged and loadctl=15.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared sequencer definitions: microword field positions, flow/cin_sel encodings,
// flag indices and idle control constants. Imported by control_sequencer and flags_reg users.
package control_sequencer_pkg;

    localparam int OUTCTL_LSB    = 0;
    localparam int LOADCTL_LSB   = 4;
    localparam int ALT_BIT       = 8;
    localparam int CALCFN_BIT    = 9;
    localparam int ARGL_LSB      = 10;
    localparam int ARGR_LSB      = 12;
    localparam int CINSEL_LSB    = 15;
    localparam int IRLOAD_BIT    = 17;
    localparam int FLAGSLOAD_BIT = 18;
    localparam int FLOW_LSB      = 19;
    localparam int COND_LSB      = 22;
    localparam int CINV_BIT      = 24;
    localparam int RESERVED_LSB  = 25;

    typedef enum logic [2:0] {
        FLOW_NEXT = 3'd0,
        FLOW_END  = 3'd1,
        FLOW_CEND = 3'd2,
        FLOW_HALT = 3'd3
    } flow_e;

    typedef enum logic [1:0] {
        CIN_ZERO   = 2'd0,
        CIN_ONE    = 2'd1,
        CIN_CARRY  = 2'd2,
        CIN_NCARRY = 2'd3
    } cin_sel_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    localparam logic [3:0] OUT_NONE  = 4'hF;
    localparam logic [3:0] LOAD_NONE = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/control_sequencer_flags_reg.sv
// flags_reg: 4-bit flag register with load enable and asynchronous active-low clear.
module flags_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: IR/step/flags state, ROM address build and microword decode.
// Optional build macro SEQ_SINGLE_STEP_EN adds a step_en input that pauses the sequencer.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int STEP_W  = 3,
    parameter int UWORD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step_en,
`endif
    input  logic [7:0]          main_bus,
    input  logic [3:0]          fout,
    output logic [7+STEP_W:0]   uaddr,
    input  logic [UWORD_W-1:0]  uword,
    output logic [3:0]          outctl,
    output logic [3:0]          loadctl,
    output logic                alt,
    output logic                calcfn,
    output logic [1:0]          arg_l,
    output logic [2:0]          arg_r,
    output logic                cin,
    output logic [3:0]          flags,
    output logic                halted
);

    logic [7:0]        ir;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    seq_state_e        state;
    logic              advance;
    logic              step_go;
    logic              cond_hit;
    flow_e             flow;
    logic              unused_reserved;

    assign unused_reserved = ^uword[UWORD_W-1:RESERVED_LSB];

`ifdef SEQ_SINGLE_STEP_EN
    assign step_go = step_en;
`else
    assign step_go = 1'b1;
`endif

    assign advance  = (state == ST_RUN) && step_go;
    assign uaddr    = {ir, step};
    assign flow     = flow_e'(uword[FLOW_LSB +: 3]);
    // CEND looks at the flags held before any flags_load in the same word.
    assign cond_hit = flags[uword[COND_LSB +: 2]] ^ uword[CINV_BIT];

    always_comb begin
        step_nxt = step + 1'b1;
        case (flow)
            FLOW_END:  step_nxt = '0;
            FLOW_CEND: if (cond_hit) step_nxt = '0;
            FLOW_HALT: step_nxt = step;
            default:   step_nxt = step + 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            halted <= 1'b0;
            ir     <= '0;
            step   <= '0;
        end else if (advance) begin
            step <= step_nxt;
            if (uword[IRLOAD_BIT]) begin
                ir <= main_bus;
            end
            if (flow == FLOW_HALT) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end
        end
    end

    flags_reg #(.W(4)) u_flags (
        .clk   (clk),
        .clr_n (rst),
        .load  (advance && uword[FLAGSLOAD_BIT]),
        .d     (fout),
        .q     (flags)
    );

    // Controls decode straight from the ROM word; reset and HALT force the idle set.
    always_comb begin
        outctl  = OUT_NONE;
        loadctl = LOAD_NONE;
        alt     = 1'b0;
        calcfn  = 1'b0;
        arg_l   = '0;
        arg_r   = '0;
        cin     = 1'b0;
        if (rst && (state == ST_RUN)) begin
            outctl  = uword[OUTCTL_LSB +: 4];
            loadctl = step_go ? uword[LOADCTL_LSB +: 4] : LOAD_NONE;
            alt     = uword[ALT_BIT];
            calcfn  = uword[CALCFN_BIT];
            arg_l   = uword[ARGL_LSB +: 2];
            arg_r   = uword[ARGR_LSB +: 3];
            case (cin_sel_e'(uword[CINSEL_LSB +: 2]))
                CIN_ZERO:   cin = 1'b0;
                CIN_ONE:    cin = 1'b1;
                CIN_CARRY:  cin = flags[FLAG_C];
                CIN_NCARRY: cin = ~flags[FLAG_C];
                default:    cin = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed walk plus randomized microwords
// compared against an integer-level sequencer model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_en;
    logic [7:0]  main_bus;
    logic [3:0]  fout;
    logic [31:0] uword;
    logic [10:0] uaddr;
    logic [3:0]  outctl, loadctl, flags;
    logic        alt, calcfn, cin, halted;
    logic [1:0]  arg_l;
    logic [2:0]  arg_r;

    int errors = 0;
    int checks = 0;

`ifdef SEQ_SINGLE_STEP_EN
    localparam bit HAS_EN = 1'b1;
`else
    localparam bit HAS_EN = 1'b0;
`endif

    int m_ir, m_step, m_flags;
    bit m_halt;

    always #5 clk = ~clk;

    control_sequencer #(.STEP_W(3), .UWORD_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step_en  (step_en),
`endif
        .main_bus (main_bus),
        .fout     (fout),
        .uaddr    (uaddr),
        .uword    (uword),
        .outctl   (outctl),
        .loadctl  (loadctl),
        .alt      (alt),
        .calcfn   (calcfn),
        .arg_l    (arg_l),
        .arg_r    (arg_r),
        .cin      (cin),
        .flags    (flags),
        .halted   (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkw(input int flow, input int irl = 0, input int fl = 0,
                                        input int cidx = 0, input int cinv = 0, input int cs = 0,
                                        input int oc = 0, input int lc = 0, input int ar = 0);
        int v;
        v = (cinv << 24) | (cidx << 22) | (flow << 19) | (fl << 18) | (irl << 17)
          | (cs << 15) | (ar << 12) | (lc << 4) | oc;
        return 32'(v);
    endfunction

    // Expected outputs come from the model state plus the word currently presented.
    task automatic check_outputs();
        int w, eo, el, ealt, ecf, eal, ear, ecin, cs, carry;
        bit en;
        w  = int'(uword);
        en = HAS_EN ? step_en : 1'b1;
        eo = 15; el = 15; ealt = 0; ecf = 0; eal = 0; ear = 0; ecin = 0;
        if (rst && !m_halt) begin
            eo    = w & 15;
            el    = en ? ((w >> 4) & 15) : 15;
            ealt  = (w >> 8) & 1;
            ecf   = (w >> 9) & 1;
            eal   = (w >> 10) & 3;
            ear   = (w >> 12) & 7;
            cs    = (w >> 15) & 3;
            carry = (m_flags >> 1) & 1;
            ecin  = (cs == 0) ? 0 : (cs == 1) ? 1 : (cs == 2) ? carry : 1 - carry;
        end
        check("uaddr",   32'(uaddr),   32'(m_ir * 8 + m_step));
        check("outctl",  32'(outctl),  32'(eo));
        check("loadctl", 32'(loadctl), 32'(el));
        check("alt",     32'(alt),     32'(ealt));
        check("calcfn",  32'(calcfn),  32'(ecf));
        check("arg_l",   32'(arg_l),   32'(eal));
        check("arg_r",   32'(arg_r),   32'(ear));
        check("cin",     32'(cin),     32'(ecin));
        check("flags",   32'(flags),   32'(m_flags));
        check("halted",  32'(halted),  32'(m_halt));
    endtask

    task automatic model_edge();
        int w, flow, cond, nstep;
        bit en;
        w  = int'(uword);
        en = HAS_EN ? step_en : 1'b1;
        if (rst && !m_halt && en) begin
            flow  = (w >> 19) & 7;
            cond  = ((m_flags >> ((w >> 22) & 3)) & 1) ^ ((w >> 24) & 1);
            nstep = (m_step + 1) % 8;
            if (flow == 1) nstep = 0;
            if (flow == 2 && cond == 1) nstep = 0;
            if (flow == 3) begin
                nstep  = m_step;
                m_halt = 1'b1;
            end
            if ((w >> 17) & 1) m_ir = int'(main_bus);
            if ((w >> 18) & 1) m_flags = int'(fout);
            m_step = nstep;
        end
    endtask

    task automatic step_cyc(input logic [31:0] w, input logic [7:0] bus = 8'h00,
                            input logic [3:0] f = 4'h0, input logic en = 1'b1);
        @(negedge clk);
        rst = 1'b1; uword = w; main_bus = bus; fout = f; step_en = en;
        #1;
        check_outputs();
        model_edge();
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst low; the next step_cyc releases it.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; uword = 32'h00FF_FFFF; main_bus = 8'hFF; fout = 4'hF; step_en = 1'b1;
        #1;
        m_ir = 0; m_step = 0; m_flags = 0; m_halt = 1'b0;
        check("rst_outctl",  32'(outctl),  32'd15);
        check("rst_loadctl", 32'(loadctl), 32'd15);
        check("rst_cin",     32'(cin),     32'd0);
        check("rst_uaddr",   32'(uaddr),   32'd0);
        check_outputs();
        settle();
        check("rst_hold_uaddr", 32'(uaddr), 32'd0);
        check("rst_hold_flags", 32'(flags), 32'd0);
    endtask

    initial begin
        int halt_cycles;
        logic [31:0] w;
        rst = 1'b0; uword = '0; main_bus = '0; fout = '0; step_en = 1'b1;
        m_ir = 0; m_step = 0; m_flags = 0; m_halt = 1'b0;

        do_reset();

        for (int i = 0; i < 8; i++) begin
            step_cyc(mkw(0, 0, 0, 0, 0, 0, i));
            check("wrap_uaddr", 32'(uaddr), 32'(i));
            check("release_halted", 32'(halted), 32'd0);
        end

        step_cyc(mkw(0, 1), 8'h2A);
        check("wrap_back", 32'(uaddr), 32'd0);
        settle();
        check("irload_uaddr", 32'(uaddr), 32'h151);
        step_cyc(mkw(0));
        step_cyc(mkw(0));
        step_cyc(mkw(1));
        check("end_pre", 32'(uaddr), 32'h153);
        settle();
        check("end_uaddr", 32'(uaddr), 32'h150);

        step_cyc(mkw(0, 0, 1), 8'h00, 4'b0110);
        settle();
        check("flags_load", 32'(flags), 32'h6);
        step_cyc(mkw(2, 0, 0, 2, 0));
        settle();
        check("cend_z_taken", 32'(uaddr), 32'h150);
        step_cyc(mkw(0));
        step_cyc(mkw(2, 0, 0, 2, 1));
        settle();
        check("cend_z_inv", 32'(uaddr), 32'h152);
        step_cyc(mkw(2, 0, 1, 2, 0), 8'h00, 4'b0000);
        settle();
        check("cend_old_flags", 32'(uaddr), 32'h150);
        check("cend_new_flags", 32'(flags), 32'h0);

        step_cyc(mkw(0, 0, 1), 8'h00, 4'b0010);
        step_cyc(mkw(0, 0, 0, 0, 0, 2));
        check("cin_carry", 32'(cin), 32'd1);
        step_cyc(mkw(0, 0, 0, 0, 0, 3));
        check("cin_ncarry", 32'(cin), 32'd0);
        step_cyc(mkw(0, 0, 0, 0, 0, 0, 2, 0, 1));
        check("pass_outctl",  32'(outctl),  32'd2);
        check("pass_loadctl", 32'(loadctl), 32'd0);
        check("pass_arg_r",   32'(arg_r),   32'd1);

        step_cyc(mkw(3));
        settle();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_outctl", 32'(outctl), 32'd15);
        for (int i = 0; i < 10; i++) begin
            step_cyc($urandom & 32'h01FF_FFFF, 8'($urandom), 4'($urandom));
            check("halt_frozen_uaddr", 32'(uaddr), 32'h154);
            check("halt_frozen_flags", 32'(flags), 32'h2);
        end
        do_reset();

`ifdef SEQ_SINGLE_STEP_EN
        step_cyc(mkw(0));
        step_cyc(mkw(0));
        for (int i = 0; i < 3; i++) begin
            step_cyc(mkw(0, 1, 1, 0, 0, 0, 5, 3), 8'h77, 4'hF, 1'b0);
            check("ss_loadctl", 32'(loadctl), 32'd15);
            check("ss_outctl",  32'(outctl),  32'd5);
            check("ss_uaddr",   32'(uaddr),   32'd2);
        end
        step_cyc(mkw(0, 0, 0, 0, 0, 0, 5, 3), 8'h00, 4'h0, 1'b1);
        check("ss_resume_loadctl", 32'(loadctl), 32'd3);
`endif

        halt_cycles = 0;
        for (int n = 0; n < 800; n++) begin
            w = $urandom & 32'h01FF_FFFF;
            if (w[21:19] == 3'd3 && $urandom_range(0, 11) != 0) w[21:19] = 3'd0;
            step_cyc(w, 8'($urandom), 4'($urandom),
                     HAS_EN ? logic'($urandom_range(0, 3) != 0) : 1'b1);
            if (m_halt) halt_cycles++;
            if (halt_cycles > 4 || $urandom_range(0, 59) == 0) begin
                halt_cycles = 0;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
